// File: rtl/keypad_matrix_scanner.sv
// 4x5 matrix keypad scanner: row strobing, 2-flop column sync, scan-level
// debounce of press and release, one key_valid strobe per accepted press.
module keypad_matrix_scanner #(
  parameter int unsigned SCAN_DIV       = 10000,
  parameter int unsigned DEBOUNCE_SCANS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] col_n,
  output logic [3:0] row_n,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_e;

  logic [4:0]       col_meta_q, col_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       row_n_q, row_n_d;
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [4:0]       acc_code_q, acc_code_d;
  state_e           state_q, state_d;
  logic [4:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic [4:0]       row_hits;
  logic [1:0]       hit_n;
  logic [2:0]       hit_col;
  logic [2:0]       hit_sum;
  logic [1:0]       scan_cnt;
  logic [4:0]       scan_code;
  logic             sample, scan_done;

  // Row timing plus running contact count/code across the rows of one scan.
  // Contact count saturates at 2, which is all MULTI detection needs.
  always_comb begin
    row_hits = ~col_sync_q;
    hit_n    = 2'd0;
    hit_col  = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (row_hits[i] && (hit_n != 2'd2)) hit_n = hit_n + 2'd1;
    end
    for (int i = 4; i >= 0; i--) begin
      if (row_hits[i]) hit_col = 3'(i);
    end
    hit_sum   = 3'(acc_cnt_q) + 3'(hit_n);
    scan_cnt  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    scan_code = (hit_n == 2'd1) ? (5'(row_idx_q) * 5'd5 + 5'(hit_col)) : acc_code_q;
    sample    = (div_q == DIV_LAST);
    scan_done = sample && (row_idx_q == 2'd3);

    div_d      = sample ? '0 : div_q + DIV_W'(1);
    row_idx_d  = row_idx_q;
    row_n_d    = row_n_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (sample) begin
      row_idx_d = row_idx_q + 2'd1;
      row_n_d   = {row_n_q[2:0], row_n_q[3]};
      if (scan_done) begin
        acc_cnt_d  = 2'd0;
        acc_code_d = 5'd0;
      end else begin
        acc_cnt_d  = scan_cnt;
        acc_code_d = scan_code;
      end
    end
  end

  logic [CNT_W-1:0] cnt_inc, new_cnt;
  logic             scan_single, scan_none;

  // Debounce FSM, stepped only on the scan-complete cycle.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    new_cnt     = CNT_ONE;
    scan_single = (scan_cnt == 2'd1);
    scan_none   = (scan_cnt == 2'd0);

    if (scan_done) begin
      case (state_q)
        IDLE, PRESS_DB: begin
          if (scan_single) begin
            new_cnt = ((state_q == PRESS_DB) && (scan_code == cand_q)) ? cnt_inc : CNT_ONE;
            cand_d  = scan_code;
            cnt_d   = new_cnt;
            if (new_cnt >= CNT_MAX) begin
              key_code_d  = scan_code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = HELD;
            end else begin
              state_d = PRESS_DB;
            end
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (scan_none) begin
            cnt_d = CNT_ONE;
            if (CNT_ONE >= CNT_MAX) begin
              key_held_d = 1'b0;
              state_d    = IDLE;
            end else begin
              state_d = REL_DB;
            end
          end
        end
        REL_DB: begin
          if (scan_none) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_MAX) begin
              key_held_d = 1'b0;
              state_d    = IDLE;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_meta_q  <= 5'h1F;
      col_sync_q  <= 5'h1F;
      div_q       <= '0;
      row_idx_q   <= 2'd0;
      row_n_q     <= 4'b1110;
      acc_cnt_q   <= 2'd0;
      acc_code_q  <= 5'd0;
      state_q     <= IDLE;
      cand_q      <= 5'd0;
      cnt_q       <= '0;
      key_code_q  <= 5'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      col_meta_q  <= col_n;
      col_sync_q  <= col_meta_q;
      div_q       <= div_d;
      row_idx_q   <= row_idx_d;
      row_n_q     <= row_n_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign row_n     = row_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural keypad model
// (SCAN_DIV=4, DEBOUNCE_SCANS=3, so one scan is 16 cycles).
module tb_keypad_matrix_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  col_n;
  logic [3:0]  row_n;
  logic [4:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [19:0] pressed;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 5'h1F;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if (pressed[r*5+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always begin
    @(posedge clk);
    #1;
    if (key_valid === 1'b1) pulse_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Leaves the caller at the negedge of the first cycle of a new scan.
  task automatic wait_scan_start(output bit ok);
    int n;
    n = 0;
    while (row_n !== 4'b0111 && n < 100) begin @(negedge clk); n++; end
    while (row_n !== 4'b1110 && n < 100) begin @(negedge clk); n++; end
    ok = (row_n === 4'b1110) && (n < 100);
  endtask

  task automatic test_reset;
    logic [3:0] exp_row [4];
    logic [3:0] er;
    exp_row[0] = 4'b1110; exp_row[1] = 4'b1101;
    exp_row[2] = 4'b1011; exp_row[3] = 4'b0111;
    reset = 1'b1;
    pressed = '0;
    tick(3);
    n_checks++; if (row_n !== 4'b1110) begin n_fail++; $display("FAIL reset_row_n: got %b, expected 1110", row_n); end
    n_checks++; if (key_code !== 5'd0) begin n_fail++; $display("FAIL reset_key_code: got %0d, expected 0", key_code); end
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b, expected 0", key_valid); end
    n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_key_held: got %b, expected 0", key_held); end
    reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      er = exp_row[(k / 4) % 4];
      n_checks++;
      if (row_n !== er) begin n_fail++; $display("FAIL idle_row_n cycle %0d: got %b, expected %b", k, row_n, er); end
      tick(1);
    end
    n_checks++; if (pulse_cnt !== 0) begin n_fail++; $display("FAIL idle_no_pulse: got %0d pulses, expected 0", pulse_cnt); end
  endtask

  task automatic test_clean_press;
    bit ok;
    int n, p0;
    wait_scan_start(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clean_scan_align: got no scan start, expected one"); end
    p0 = pulse_cnt;
    pressed[13] = 1'b1;
    n = 0;
    while (key_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_checks++; if (n != 48) begin n_fail++; $display("FAIL clean_latency: got %0d cycles, expected 48", n); end
    n_checks++; if (key_code !== 5'd13) begin n_fail++; $display("FAIL clean_code: got %0d, expected 13", key_code); end
    n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL clean_held: got %b, expected 1", key_held); end
    n_checks++; if (row_n !== 4'b1110) begin n_fail++; $display("FAIL clean_pulse_row: got %b, expected 1110", row_n); end
    tick(1);
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL clean_pulse_width: got %b, expected 0", key_valid); end
    wait_scan_start(ok);
    pressed[13] = 1'b0;
    tick(47);
    n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL clean_held_before_release: got %b, expected 1", key_held); end
    tick(1);
    n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL clean_release: got %b, expected 0", key_held); end
    n_checks++; if (pulse_cnt - p0 != 1) begin n_fail++; $display("FAIL clean_pulse_count: got %0d, expected 1", pulse_cnt - p0); end
  endtask

  task automatic test_bounce;
    bit ok;
    int n, p0;
    wait_scan_start(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bounce_scan_align: got no scan start, expected one"); end
    p0 = pulse_cnt;
    pressed[7] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(5);
      pressed[7] = ~pressed[7];
    end
    n_checks++; if (pulse_cnt != p0) begin n_fail++; $display("FAIL bounce_quiet: got %0d pulses, expected 0", pulse_cnt - p0); end
    n = 0;
    while (key_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL bounce_accept: got no pulse in %0d cycles, expected one", n); end
    n_checks++; if (key_code !== 5'd7) begin n_fail++; $display("FAIL bounce_code: got %0d, expected 7", key_code); end
    tick(100);
    n_checks++; if (pulse_cnt - p0 != 1) begin n_fail++; $display("FAIL bounce_pulse_count: got %0d, expected 1", pulse_cnt - p0); end
    pressed[7] = 1'b0;
    n = 0;
    while (key_held !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL bounce_release: got %b, expected 0", key_held); end
  endtask

  task automatic test_multi_key;
    int n, p0;
    p0 = pulse_cnt;
    pressed[0] = 1'b1;
    pressed[6] = 1'b1;
    tick(128);
    n_checks++; if (pulse_cnt != p0) begin n_fail++; $display("FAIL multi_no_pulse: got %0d pulses, expected 0", pulse_cnt - p0); end
    n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL multi_not_held: got %b, expected 0", key_held); end
    pressed[6] = 1'b0;
    n = 0;
    while (key_valid !== 1'b1 && n < 120) begin @(negedge clk); n++; end
    n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL multi_single_accept: got no pulse, expected one"); end
    n_checks++; if (key_code !== 5'd0) begin n_fail++; $display("FAIL multi_code: got %0d, expected 0", key_code); end
    tick(64);
    n_checks++; if (pulse_cnt - p0 != 1) begin n_fail++; $display("FAIL multi_pulse_count: got %0d, expected 1", pulse_cnt - p0); end
    pressed[0] = 1'b0;
    n = 0;
    while (key_held !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL multi_release: got %b, expected 0", key_held); end
  endtask

  task automatic test_rollover;
    int n, p0;
    pressed[19] = 1'b1;
    n = 0;
    while (key_valid !== 1'b1 && n < 120) begin @(negedge clk); n++; end
    n_checks++; if (key_code !== 5'd19 || key_valid !== 1'b1) begin n_fail++; $display("FAIL roll_accept: got code %0d valid %b, expected 19 and 1", key_code, key_valid); end
    p0 = pulse_cnt;
    pressed[4] = 1'b1;
    tick(64);
    n_checks++; if (pulse_cnt != p0) begin n_fail++; $display("FAIL roll_second_key: got %0d pulses, expected 0", pulse_cnt - p0); end
    n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL roll_held_both: got %b, expected 1", key_held); end
    pressed[19] = 1'b0;
    tick(80);
    n_checks++; if (pulse_cnt != p0) begin n_fail++; $display("FAIL roll_release_first: got %0d pulses, expected 0", pulse_cnt - p0); end
    n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL roll_held_one: got %b, expected 1", key_held); end
    n_checks++; if (key_code !== 5'd19) begin n_fail++; $display("FAIL roll_code_kept: got %0d, expected 19", key_code); end
    pressed[4] = 1'b0;
    n = 0;
    while (key_held !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL roll_release_all: got %b, expected 0", key_held); end
    n_checks++; if (pulse_cnt != p0) begin n_fail++; $display("FAIL roll_no_new_pulse: got %0d pulses, expected 0", pulse_cnt - p0); end
  endtask

  task automatic test_reset_mid_press;
    bit ok;
    int n, p0;
    wait_scan_start(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_scan_align: got no scan start, expected one"); end
    p0 = pulse_cnt;
    pressed[5] = 1'b1;
    tick(32);
    n_checks++; if (pulse_cnt != p0) begin n_fail++; $display("FAIL rst_before: got %0d pulses, expected 0", pulse_cnt - p0); end
    reset = 1'b1;
    tick(1);
    n_checks++; if (row_n !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got row %b valid %b held %b, expected 1110 0 0", row_n, key_valid, key_held);
    end
    reset = 1'b0;
    n = 0;
    while (key_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_checks++; if (n != 48) begin n_fail++; $display("FAIL rst_restart_latency: got %0d cycles, expected 48", n); end
    n_checks++; if (key_code !== 5'd5) begin n_fail++; $display("FAIL rst_code: got %0d, expected 5", key_code); end
    n_checks++; if (pulse_cnt - p0 != 1) begin n_fail++; $display("FAIL rst_pulse_count: got %0d, expected 1", pulse_cnt - p0); end
    pressed[5] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pressed = '0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_rollover();
    test_reset_mid_press();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
